simt_pc: RTL and testbench

SIMT_PC -- requirements
Module: simt_pc

---
 rtl/simt_pc.sv | 190 +++++++++++++++++++
 tb/tb_simt_pc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/simt_pc.sv
// simt_pc: SIMT next-PC unit with per-lane NZP flags and a divergence/reconvergence stack.
// Ports: clk/reset (sync, active-high), enable, core_state, thread_enable, decoded_* fields,
//   alu_out/rs_value (lane i at [i*W +: W]), current_pc -> next_pc, active_mask, stack_depth,
//   stack_overflow. next_pc/active_mask update one cycle after an enabled EXECUTE cycle.
// Optional feature macro SIMT_DIVERGENCE_EN: builds the reconvergence stack. Without it,
//   branches follow the leader lane, SYNC acts as PC+1 and the mask stays all ones.
module simt_pc #(
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic [2:0]                                      core_state,
  input  logic [THREADS_PER_BLOCK-1:0]                    thread_enable,
  input  logic [2:0]                                      decoded_nzp,
  input  logic [DATA_MEM_DATA_BITS-1:0]                   decoded_immediate,
  input  logic                                            decoded_nzp_write_enable,
  input  logic [1:0]                                      decoded_pc_mux,
  input  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] alu_out,
  input  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] rs_value,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]                current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                next_pc,
  output logic [THREADS_PER_BLOCK-1:0]                    active_mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0]                stack_depth,
  output logic                                            stack_overflow
);
  localparam int W   = DATA_MEM_DATA_BITS;
  localparam int A   = PROGRAM_MEM_ADDR_BITS;
  localparam int N   = THREADS_PER_BLOCK;
  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;

  logic [2:0]   nzp [N];
  logic [N-1:0] eff;
  logic [N-1:0] taken;
  logic [W-1:0] leader_rs;
  logic         leader_taken;
  logic [A-1:0] imm_pc;
  logic [A-1:0] leader_pc;
  logic [A-1:0] pc_inc;
  logic [A-1:0] pc_d;

  // Only the low three bits of each ALU lane feed the NZP flags.
  logic unused_alu;
  assign unused_alu = ^alu_out;

`ifdef SIMT_DIVERGENCE_EN
  localparam int D   = STACK_DEPTH;
  localparam int SDW = $clog2(STACK_DEPTH+1);
  localparam int IW  = (D > 1) ? $clog2(D) : 1;

  logic [N-1:0]  stk_fmask [D];
  logic [A-1:0]  stk_tpc   [D];
  logic [N-1:0]  stk_tmask [D];
  logic          stk_phase [D];
  logic [N-1:0]  mask_d;
  logic          push, pop, phase_set, ovf_set, stk_full;
  logic [IW-1:0] top, push_idx;

  assign stk_full = (stack_depth == SDW'(D));
  assign top      = IW'(stack_depth - SDW'(1));
  assign push_idx = IW'(stack_depth);
`else
  assign active_mask    = '1;
  assign stack_depth    = '0;
  assign stack_overflow = 1'b0;
`endif

  assign eff    = active_mask & thread_enable;
  assign pc_inc = current_pc + A'(1);

  // Immediate and Rs values are resized to the PC width.
  if (A > W) begin : g_ext
    assign imm_pc    = {{(A-W){1'b0}}, decoded_immediate};
    assign leader_pc = {{(A-W){1'b0}}, leader_rs};
  end else begin : g_trunc
    assign imm_pc    = decoded_immediate[A-1:0];
    assign leader_pc = leader_rs[A-1:0];
  end

  // Taken mask, plus the leader (lowest set bit of eff): descending scan so lowest wins.
  always_comb begin
    taken        = '0;
    leader_rs    = '0;
    leader_taken = 1'b0;
    for (int i = 0; i < N; i++) taken[i] = eff[i] & (|(nzp[i] & decoded_nzp));
    for (int i = N-1; i >= 0; i--) begin
      if (eff[i]) begin
        leader_rs    = rs_value[i*W +: W];
        leader_taken = taken[i];
      end
    end
  end

  always_comb begin
    pc_d = pc_inc;
`ifdef SIMT_DIVERGENCE_EN
    mask_d    = active_mask;
    push      = 1'b0;
    pop       = 1'b0;
    phase_set = 1'b0;
    ovf_set   = 1'b0;
`endif
    // With no valid lanes every mode degenerates to PC+1.
    if (eff != '0) begin
      case (decoded_pc_mux)
        2'd1: begin
          if (taken == eff) begin
            pc_d = imm_pc;
          end else if (taken != '0) begin
`ifdef SIMT_DIVERGENCE_EN
            if (!stk_full) begin
              // Run the not-taken side first; the taken side resumes at SYNC.
              push   = 1'b1;
              mask_d = active_mask & ~taken;
            end else begin
              ovf_set = 1'b1;
              if (leader_taken) pc_d = imm_pc;
            end
`else
            if (leader_taken) pc_d = imm_pc;
`endif
          end
        end
        2'd2: pc_d = leader_pc;
`ifdef SIMT_DIVERGENCE_EN
        2'd3: begin
          if (stack_depth != '0) begin
            if (!stk_phase[top]) begin
              pc_d      = stk_tpc[top];
              mask_d    = stk_tmask[top];
              phase_set = 1'b1;
            end else begin
              pop    = 1'b1;
              mask_d = stk_fmask[top];
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc <= '0;
      for (int i = 0; i < N; i++) nzp[i] <= 3'b000;
    end else if (enable) begin
      if (core_state == EXECUTE) next_pc <= pc_d;
      if (core_state == UPDATE && decoded_nzp_write_enable) begin
        for (int i = 0; i < N; i++) begin
          if (eff[i]) nzp[i] <= alu_out[i*W +: 3];
        end
      end
    end
  end

`ifdef SIMT_DIVERGENCE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      active_mask    <= '1;
      stack_depth    <= '0;
      stack_overflow <= 1'b0;
    end else if (enable && core_state == EXECUTE) begin
      active_mask <= mask_d;
      if (push)    stack_depth    <= stack_depth + SDW'(1);
      if (pop)     stack_depth    <= stack_depth - SDW'(1);
      if (ovf_set) stack_overflow <= 1'b1;
    end
  end

  // Stack storage carries no reset; entries above stack_depth are never read.
  always_ff @(posedge clk) begin
    if (!reset && enable && core_state == EXECUTE) begin
      if (push) begin
        stk_fmask[push_idx] <= active_mask;
        stk_tpc[push_idx]   <= imm_pc;
        stk_tmask[push_idx] <= taken;
        stk_phase[push_idx] <= 1'b0;
      end
      if (phase_set) stk_phase[top] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simt_pc.sv
module tb_simt_pc;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int A  = 8;
  localparam int SD = 2;
`ifdef SIMT_DIVERGENCE_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b1;
  logic [2:0]     core_state = 3'b000;
  logic [N-1:0]   thread_enable = 4'hF;
  logic [2:0]     decoded_nzp = 3'b000;
  logic [W-1:0]   decoded_immediate = '0;
  logic           decoded_nzp_write_enable = 1'b0;
  logic [1:0]     decoded_pc_mux = 2'd0;
  logic [N*W-1:0] alu_out = '0;
  logic [N*W-1:0] rs_value = 32'h9977_4211;
  logic [A-1:0]   current_pc = '0;
  logic [A-1:0]   next_pc;
  logic [N-1:0]   active_mask;
  logic [1:0]     stack_depth;
  logic           stack_overflow;

  simt_pc #(.DATA_MEM_DATA_BITS(W), .PROGRAM_MEM_ADDR_BITS(A),
            .THREADS_PER_BLOCK(N), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .thread_enable(thread_enable), .decoded_nzp(decoded_nzp),
    .decoded_immediate(decoded_immediate),
    .decoded_nzp_write_enable(decoded_nzp_write_enable),
    .decoded_pc_mux(decoded_pc_mux), .alu_out(alu_out), .rs_value(rs_value),
    .current_pc(current_pc), .next_pc(next_pc), .active_mask(active_mask),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] mask;
    logic [1:0] depth;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic obs_vld = 1'b0;

  function automatic exp_t mk(input logic [7:0] pc, input logic [3:0] mask,
                              input logic [1:0] depth, input logic ovf);
    exp_t e;
    e.pc = pc; e.mask = mask; e.depth = depth; e.ovf = ovf;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // An output is presented the cycle after any reset or EXECUTE cycle (enabled or not).
  always @(posedge clk) obs_vld <= reset || (core_state == EXECUTE);

  always @(negedge clk) begin
    if (obs_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("next_pc", int'(next_pc), int'(mon_e.pc));
        chk("active_mask", int'(active_mask), int'(mon_e.mask));
        chk("stack_depth", int'(stack_depth), int'(mon_e.depth));
        chk("stack_overflow", int'(stack_overflow), int'(mon_e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] alu, input logic [3:0] te);
    core_state = UPDATE;
    decoded_nzp_write_enable = 1'b1;
    alu_out = alu;
    thread_enable = te;
    tick();
    core_state = 3'b000;
    decoded_nzp_write_enable = 1'b0;
  endtask

  task automatic ex(input logic [1:0] mux, input logic [7:0] pc, input logic [7:0] imm,
                    input logic [2:0] dn, input logic [3:0] te, input exp_t e);
    core_state = EXECUTE;
    decoded_pc_mux = mux;
    current_pc = pc;
    decoded_immediate = imm;
    decoded_nzp = dn;
    thread_enable = te;
    q.push_back(e);
    tick();
    core_state = 3'b000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.push_back(mk(8'h00, 4'hF, 2'd0, 1'b0));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    // Uniform branch: every lane 010.
    upd(32'h0202_0202, 4'hF);
    ex(2'd1, 8'h05, 8'h20, 3'b010, 4'hF, mk(8'h20, 4'hF, 2'd0, 1'b0));
    // PC wrap.
    ex(2'd0, 8'hFF, 8'h00, 3'b000, 4'hF, mk(8'h00, 4'hF, 2'd0, 1'b0));
    // JMP: leader is lane 1 (rs 0x42), not lane 0 (0x11).
    ex(2'd2, 8'h33, 8'h00, 3'b000, 4'b0110, mk(8'h42, 4'hF, 2'd0, 1'b0));
    // Nobody taken.
    ex(2'd1, 8'h07, 8'h60, 3'b001, 4'hF, mk(8'h08, 4'hF, 2'd0, 1'b0));
    // No valid lanes: JMP and a would-be-taken branch both give PC+1.
    ex(2'd2, 8'h40, 8'h00, 3'b000, 4'h0, mk(8'h41, 4'hF, 2'd0, 1'b0));
    ex(2'd1, 8'h41, 8'h70, 3'b010, 4'h0, mk(8'h42, 4'hF, 2'd0, 1'b0));
    // Disabled EXECUTE holds state.
    enable = 1'b0;
    ex(2'd2, 8'h00, 8'h00, 3'b000, 4'hF, mk(8'h42, 4'hF, 2'd0, 1'b0));
    enable = 1'b1;
    // Divergence and reconvergence: lanes 0,1 = 100, lanes 2,3 = 001.
    upd(32'h0101_0404, 4'hF);
    ex(2'd1, 8'h10, 8'h30, 3'b100, 4'hF,
       mk(DIV ? 8'h11 : 8'h30, DIV ? 4'b1100 : 4'hF, DIV ? 2'd1 : 2'd0, 1'b0));
    ex(2'd3, 8'h18, 8'h00, 3'b000, 4'hF,
       mk(DIV ? 8'h30 : 8'h19, DIV ? 4'b0011 : 4'hF, DIV ? 2'd1 : 2'd0, 1'b0));
    ex(2'd3, 8'h34, 8'h00, 3'b000, 4'hF, mk(8'h35, 4'hF, 2'd0, 1'b0));
    // NZP write gated by lane enable: lane0 -> 010; the te=0 write must be ignored.
    upd(32'h0202_0202, 4'b0001);
    upd(32'h0707_0707, 4'b0000);
    // nzp now: lane0 010, lane1 100, lanes2,3 001. Only lane1 takes; leader lane0 does not.
    ex(2'd1, 8'h20, 8'h50, 3'b100, 4'hF,
       mk(8'h21, DIV ? 4'b1101 : 4'hF, DIV ? 2'd1 : 2'd0, 1'b0));
    // Nested: E=1101 (div) -> only lane0 takes; leader lane0 taken (non-div).
    ex(2'd1, 8'h22, 8'h60, 3'b110, 4'hF,
       mk(DIV ? 8'h23 : 8'h60, DIV ? 4'b1100 : 4'hF, DIV ? 2'd2 : 2'd0, 1'b0));
    // Div: lanes 2,3 get 001/100 (lanes 0,1 outside E). Non-div: lanes 0,1 get 111.
    upd(32'h0401_0707, 4'hF);
    // Div: stack full, T=0100 -> overflow, leader lane2 taken. Non-div: leader lane0 taken.
    ex(2'd1, 8'h30, 8'h70, 3'b001, 4'hF,
       mk(8'h70, DIV ? 4'b1100 : 4'hF, DIV ? 2'd2 : 2'd0, DIV));
    // Reset mid-divergence clears everything, including nzp.
    do_reset();
    ex(2'd1, 8'h05, 8'h99, 3'b111, 4'hF, mk(8'h06, 4'hF, 2'd0, 1'b0));
    // SYNC with empty stack.
    ex(2'd3, 8'h06, 8'h00, 3'b000, 4'hF, mk(8'h07, 4'hF, 2'd0, 1'b0));
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
